// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: turns stall/flush/branch-hazard requests into pipeline enables, bubbles and PC redirects
module pipeline_hazard_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_DEPTH  = 1,
    parameter int BR_TIMEOUT   = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             ctrl_hazard_i,
    input  logic             br_resolved_i,
    input  logic             br_taken_i,
    output logic             pc_en_o,
    output logic             pc_redirect_o,
    output logic             if_id_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             busy_o,
    output logic             hazard_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    localparam int MAXC = STALL_CYCLES > FLUSH_DEPTH ? STALL_CYCLES : FLUSH_DEPTH;
    localparam int CW = $clog2(MAXC + 1);
    localparam int TW = $clog2(BR_TIMEOUT + 1);
    typedef enum logic [1:0] {RUN, FLUSH, STALL, BR_WAIT} stateT;
    stateT state, nextState;
    logic [CW-1:0] cnt, nextCnt;
    logic [TW-1:0] tmo, nextTmo;
    logic doFlush, doHold, drain, setErr;
    always_comb begin
        doFlush = 1'b0;
        doHold = 1'b0;
        drain = 1'b0;
        setErr = 1'b0;
        nextState = state;
        nextCnt = cnt;
        nextTmo = tmo;
        case (state)
            RUN: begin
                if (flush_i || (ctrl_hazard_i && br_resolved_i && br_taken_i)) doFlush = 1'b1;
                else if (ctrl_hazard_i && !br_resolved_i) begin
                    doHold = 1'b1;
                    nextState = BR_WAIT;
                    nextTmo = TW'(BR_TIMEOUT - 1);
                end else if (stall_i && !ctrl_hazard_i) begin
                    doHold = 1'b1;
                    nextState = STALL_CYCLES > 1 ? STALL : RUN;
                    nextCnt = CW'(STALL_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (flush_i) doFlush = 1'b1;
                else begin
                    drain = 1'b1;
                    nextState = cnt == CW'(1) ? RUN : FLUSH;
                    nextCnt = cnt - 1'b1;
                end
            end
            STALL: begin
                if (flush_i) doFlush = 1'b1;
                else begin
                    doHold = 1'b1;
                    nextState = cnt == CW'(1) ? RUN : STALL;
                    nextCnt = cnt - 1'b1;
                end
            end
            default: begin
                if (flush_i || (br_resolved_i && br_taken_i)) doFlush = 1'b1;
                else if (br_resolved_i) nextState = RUN;
                else if (tmo == '0) begin
                    setErr = 1'b1;
                    nextState = RUN;
                end else begin
                    doHold = 1'b1;
                    nextTmo = tmo - 1'b1;
                end
            end
        endcase
        if (doFlush) begin
            nextState = FLUSH_DEPTH > 1 ? FLUSH : RUN;
            nextCnt = CW'(FLUSH_DEPTH - 1);
        end
    end
    assign pc_en_o       = rstn_i && !doHold;
    assign pc_redirect_o = rstn_i && doFlush;
    assign if_id_en_o    = rstn_i && !doHold && !doFlush && !drain;
    assign if_id_flush_o = !rstn_i || doFlush || drain;
    assign id_ex_flush_o = !rstn_i || doFlush || drain || doHold;
    assign busy_o        = state != RUN;
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= RUN;
            cnt <= '0;
            tmo <= '0;
            hazard_err_o <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state <= nextState;
            cnt <= nextCnt;
            tmo <= nextTmo;
            if (setErr) hazard_err_o <= 1'b1;
            if (doHold && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
            if (doFlush && !(&flush_cnt_o)) flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors feed an expectation queue; a negedge monitor pops and compares
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rstn, stall, flush, ch, res, tak;
    logic pcEn, redir, ifEn, ifFl, idFl, busy, err;
    logic [3:0] sc, fc;
    int compared = 0;
    int mismatched = 0;
    int stepId = 0;
    typedef struct {
        int id;
        logic [6:0] o;
        logic [3:0] sc;
        logic [3:0] fc;
    } expT;
    expT q[$];
    pipeline_hazard_ctrl #(.STALL_CYCLES(2), .FLUSH_DEPTH(2), .BR_TIMEOUT(4), .CNT_W(4)) dut (
        .clk_i(clk), .rstn_i(rstn), .stall_i(stall), .flush_i(flush), .ctrl_hazard_i(ch),
        .br_resolved_i(res), .br_taken_i(tak), .pc_en_o(pcEn), .pc_redirect_o(redir),
        .if_id_en_o(ifEn), .if_id_flush_o(ifFl), .id_ex_flush_o(idFl), .busy_o(busy),
        .hazard_err_o(err), .stall_cnt_o(sc), .flush_cnt_o(fc)
    );
    always #5 clk = ~clk;
    // inputs {rstn,stall,flush,ch,res,tak}; flags {pcEn,redir,ifEn,ifFl,idFl,busy,err}
    task automatic t(input logic [5:0] in, input logic [6:0] o, input logic [3:0] es, input logic [3:0] ef);
        expT e;
        #1 {rstn, stall, flush, ch, res, tak} = in;
        e.id = stepId;
        e.o = o;
        e.sc = es;
        e.fc = ef;
        q.push_back(e);
        stepId++;
        @(posedge clk);
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            expT e;
            e = q.pop_front();
            compared++;
            if ({pcEn, redir, ifEn, ifFl, idFl, busy, err} !== e.o || sc !== e.sc || fc !== e.fc) begin
                mismatched++;
                $display("FAIL step%0d: got flags=%b stall_cnt=%0d flush_cnt=%0d, want flags=%b stall_cnt=%0d flush_cnt=%0d",
                         e.id, {pcEn, redir, ifEn, ifFl, idFl, busy, err}, sc, fc, e.o, e.sc, e.fc);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        {rstn, stall, flush, ch, res, tak} = 6'b0;
        @(posedge clk);
        repeat (3) t(6'b000000, 7'b0001100, 4'd0, 4'd0);
        t(6'b100000, 7'b1010000, 4'd0, 4'd0);
        t(6'b110000, 7'b0000100, 4'd0, 4'd0);
        t(6'b100000, 7'b0000110, 4'd1, 4'd0);
        t(6'b100000, 7'b1010000, 4'd2, 4'd0);
        t(6'b111000, 7'b1101100, 4'd2, 4'd0);
        t(6'b100000, 7'b1001110, 4'd2, 4'd1);
        t(6'b100000, 7'b1010000, 4'd2, 4'd1);
        t(6'b110000, 7'b0000100, 4'd2, 4'd1);
        t(6'b101000, 7'b1101110, 4'd3, 4'd1);
        t(6'b100000, 7'b1001110, 4'd3, 4'd2);
        t(6'b100000, 7'b1010000, 4'd3, 4'd2);
        t(6'b101000, 7'b1101100, 4'd3, 4'd2);
        t(6'b101000, 7'b1101110, 4'd3, 4'd3);
        t(6'b100000, 7'b1001110, 4'd3, 4'd4);
        t(6'b100000, 7'b1010000, 4'd3, 4'd4);
        t(6'b100100, 7'b0000100, 4'd3, 4'd4);
        t(6'b100100, 7'b0000110, 4'd4, 4'd4);
        t(6'b100100, 7'b0000110, 4'd5, 4'd4);
        t(6'b100111, 7'b1101110, 4'd6, 4'd4);
        t(6'b100000, 7'b1001110, 4'd6, 4'd5);
        t(6'b100000, 7'b1010000, 4'd6, 4'd5);
        t(6'b100100, 7'b0000100, 4'd6, 4'd5);
        t(6'b100010, 7'b1010010, 4'd7, 4'd5);
        t(6'b100000, 7'b1010000, 4'd7, 4'd5);
        t(6'b100111, 7'b1101100, 4'd7, 4'd5);
        t(6'b100000, 7'b1001110, 4'd7, 4'd6);
        t(6'b100110, 7'b1010000, 4'd7, 4'd6);
        t(6'b100100, 7'b0000100, 4'd7, 4'd6);
        t(6'b100000, 7'b0000110, 4'd8, 4'd6);
        t(6'b100000, 7'b0000110, 4'd9, 4'd6);
        t(6'b100000, 7'b0000110, 4'd10, 4'd6);
        t(6'b100010, 7'b1010010, 4'd11, 4'd6);
        t(6'b100000, 7'b1010000, 4'd11, 4'd6);
        t(6'b100100, 7'b0000100, 4'd11, 4'd6);
        t(6'b100100, 7'b0000110, 4'd12, 4'd6);
        t(6'b100100, 7'b0000110, 4'd13, 4'd6);
        t(6'b100100, 7'b0000110, 4'd14, 4'd6);
        t(6'b100100, 7'b1010010, 4'd15, 4'd6);
        t(6'b100000, 7'b1010001, 4'd15, 4'd6);
        t(6'b110000, 7'b0000101, 4'd15, 4'd6);
        t(6'b100000, 7'b0000111, 4'd15, 4'd6);
        t(6'b100000, 7'b1010001, 4'd15, 4'd6);
        t(6'b100100, 7'b0000101, 4'd15, 4'd6);
        t(6'b000100, 7'b0001111, 4'd15, 4'd6);
        t(6'b000000, 7'b0001100, 4'd0, 4'd0);
        t(6'b100000, 7'b1010000, 4'd0, 4'd0);
        t(6'b100000, 7'b1010000, 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
